// File: rtl/ppl_march.sv
// ppl_march: fixed-step voxel ray marcher; one ray in flight, at most one framebuffer write per pass.
// Optional build macro PPL_MARCH_SHADE_EN darkens hits whose last step crossed an x-face.
module ppl_march #(
    parameter int unsigned MAX_STEPS = 32,
    parameter int unsigned MAX_PASS  = 15,
    parameter int unsigned WORLD     = 64,
    parameter logic [15:0] SKY_COLOR = 16'h867D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] start_pos_x,
    input  logic [17:0] start_pos_y,
    input  logic [17:0] start_pos_z,
    input  logic [19:0] ray_slope_x,
    input  logic [19:0] ray_slope_y,
    input  logic [19:0] ray_slope_z,
    input  logic [19:0] pixel_addr,
    input  logic [3:0]  block_cnt,
    output logic        blk_req,
    output logic [5:0]  blk_x,
    output logic [5:0]  blk_y,
    output logic [5:0]  blk_z,
    input  logic        blk_ack,
    input  logic        blk_solid,
    input  logic [15:0] blk_color,
    output logic [17:0] end_pos_x,
    output logic [17:0] end_pos_y,
    output logic [17:0] end_pos_z,
    output logic [19:0] ray_slope_out_x,
    output logic [19:0] ray_slope_out_y,
    output logic [19:0] ray_slope_out_z,
    output logic [19:0] pixel_addr_out,
    output logic [3:0]  block_cnt_out,
    output logic        next_en,
    output logic        pass_done,
    output logic        pix_we,
    output logic [19:0] pix_addr,
    output logic [15:0] pix_data
);
    localparam int unsigned SW       = $clog2(MAX_STEPS + 1);
    localparam logic [SW-1:0] StepMax = SW'(MAX_STEPS);
    localparam logic [3:0] PassMax    = 4'(MAX_PASS);
    localparam logic [6:0] WorldLim   = 7'(WORLD);

    typedef enum logic [1:0] {StIdle, StStep, StLookup, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0][17:0]  pos_q, pos_d;
    logic [2:0][19:0]  slope_q, slope_d;
    logic [19:0]       pa_q, pa_d;
    logic [3:0]        bc_q, bc_d;
    logic [SW-1:0]     step_q, step_d;
    logic [2:0][17:0]  end_pos_q, end_pos_d;
    logic [2:0][19:0]  slope_out_q, slope_out_d;
    logic [19:0]       pa_out_q, pa_out_d;
    logic [3:0]        bc_out_q, bc_out_d;
    logic              next_en_q, next_en_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [19:0]       waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
`ifdef PPL_MARCH_SHADE_EN
    logic              hit_x_q, hit_x_d;
`endif

    logic [2:0][18:0]  npos;
    logic              oob;
    logic              finish, write, fin_next;
    logic [15:0]       fin_color, hit_color;
    logic [3:0]        fin_bc;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        slope_d     = slope_q;
        pa_d        = pa_q;
        bc_d        = bc_q;
        step_d      = step_q;
        end_pos_d   = end_pos_q;
        slope_out_d = slope_out_q;
        pa_out_d    = pa_out_q;
        bc_out_d    = bc_out_q;
        next_en_d   = next_en_q;
        done_d      = 1'b0;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        finish      = 1'b0;
        write       = 1'b0;
        fin_next    = 1'b1;
        fin_color   = SKY_COLOR;
        fin_bc      = bc_q;
        oob         = 1'b0;
`ifdef PPL_MARCH_SHADE_EN
        hit_x_d     = hit_x_q;
        hit_color   = hit_x_q ? {1'b0, blk_color[15:12], 1'b0, blk_color[10:6],
                                 1'b0, blk_color[4:1]} : blk_color;
`else
        hit_color   = blk_color;
`endif
        // 19-bit add: bit 18 catches both overflow and a step below zero
        for (int a = 0; a < 3; a++) begin
            npos[a] = {1'b0, pos_q[a]} + slope_q[a][18:0];
            oob     = oob | npos[a][18] | ({1'b0, npos[a][17:12]} >= WorldLim);
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    pos_d   = {start_pos_z, start_pos_y, start_pos_x};
                    slope_d = {ray_slope_z, ray_slope_y, ray_slope_x};
                    pa_d    = pixel_addr;
                    bc_d    = block_cnt;
                    step_d  = '0;
                    state_d = StStep;
                end
            end
            StStep: begin
                if (oob) begin
                    finish = 1'b1;
                    write  = 1'b1;
                end else begin
                    for (int a = 0; a < 3; a++) pos_d[a] = npos[a][17:0];
                    step_d  = step_q + SW'(1);
`ifdef PPL_MARCH_SHADE_EN
                    hit_x_d = (npos[0][17:12] != pos_q[0][17:12]);
`endif
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (blk_ack) begin
                    if (blk_solid) begin
                        finish    = 1'b1;
                        write     = 1'b1;
                        fin_color = hit_color;
                    end else if (step_q < StepMax) begin
                        state_d = StStep;
                    end else if (bc_q >= PassMax) begin
                        finish = 1'b1;
                        write  = 1'b1;
                    end else begin
                        finish   = 1'b1;
                        fin_next = 1'b0;
                        fin_bc   = bc_q + 4'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (finish) begin
            state_d     = StDone;
            done_d      = 1'b1;
            next_en_d   = fin_next;
            end_pos_d   = pos_q;
            slope_out_d = slope_q;
            pa_out_d    = pa_q;
            bc_out_d    = fin_bc;
        end
        if (write) begin
            we_d    = 1'b1;
            waddr_d = pa_q;
            wdata_d = fin_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pos_q       <= '0;
            slope_q     <= '0;
            pa_q        <= '0;
            bc_q        <= '0;
            step_q      <= '0;
            end_pos_q   <= '0;
            slope_out_q <= '0;
            pa_out_q    <= '0;
            bc_out_q    <= '0;
            next_en_q   <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
`ifdef PPL_MARCH_SHADE_EN
            hit_x_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            slope_q     <= slope_d;
            pa_q        <= pa_d;
            bc_q        <= bc_d;
            step_q      <= step_d;
            end_pos_q   <= end_pos_d;
            slope_out_q <= slope_out_d;
            pa_out_q    <= pa_out_d;
            bc_out_q    <= bc_out_d;
            next_en_q   <= next_en_d;
            done_q      <= done_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
`ifdef PPL_MARCH_SHADE_EN
            hit_x_q     <= hit_x_d;
`endif
        end
    end

    assign in_ready        = (state_q == StIdle);
    assign blk_req         = (state_q == StLookup);
    assign blk_x           = pos_q[0][17:12];
    assign blk_y           = pos_q[1][17:12];
    assign blk_z           = pos_q[2][17:12];
    assign end_pos_x       = end_pos_q[0];
    assign end_pos_y       = end_pos_q[1];
    assign end_pos_z       = end_pos_q[2];
    assign ray_slope_out_x = slope_out_q[0];
    assign ray_slope_out_y = slope_out_q[1];
    assign ray_slope_out_z = slope_out_q[2];
    assign pixel_addr_out  = pa_out_q;
    assign block_cnt_out   = bc_out_q;
    assign next_en         = next_en_q;
    assign pass_done       = done_q;
    assign pix_we          = we_q;
    assign pix_addr        = waddr_q;
    assign pix_data        = wdata_q;

endmodule
